vect_instr_fetch: RTL and testbench
===================================

Name: vect_instr_fetch

Overview:
- Vector-side consumer of the scalar-to-vector instruction buffer.
- Pops instructions from the first-word-fall-through issue FIFO and classifies each one.
- Executes vsetivli locally, updating the vector length and lane enables.
- Dispatches vector arithmetic and memory instructions to the execution stage over a valid/ready handshake, serialising memory ops until completion; rejects non-vector opcodes.

Parameters:
- INSTR_WIDTH, 32: instruction width. The decode fields below assume 32.
- LANES, 4: number of vector lanes. Must be a power of two, at least 2.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- instr_i  in  INSTR_WIDTH  head of issue FIFO; valid while buf_empty_i=0.
- buf_empty_i  in  1  issue FIFO empty.
- buf_read_o  out  1  pop strobe (combinational). Consumes the head at the clock edge.
- instr_o  out  INSTR_WIDTH  instruction to the execution stage.
- instr_valid_o  out  1  instr_o valid.
- instr_ready_i  in  1  execution stage accepts.
- mem_done_i  in  1  one-cycle pulse: the outstanding vector load/store has completed.
- vl_o  out  $clog2(LANES)+1  current vector length.
- lane_en_o  out  LANES  per-lane enable; bit i = (i < vl_o).
- illegal_o  out  1  one-cycle pulse: a non-vector instruction was popped and dropped.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset:
  - state=IDLE, holding register cleared.
  - instr_valid_o=0, buf_read_o=0, illegal_o=0, busy_o=0.
  - vl_o=LANES, lane_en_o all ones.
  - Reset mid-operation discards any held instruction; no pop occurs during reset.
- Classification of the popped word, on opcode = instr_i[6:0]:
  - 0x57 with instr_i[14:12]=3'b111 and instr_i[31:30]=2'b11 -> SETVL.
  - Any other 0x57 -> ARITH.
  - 0x07 or 0x27 -> MEM.
  - Anything else -> ILLEGAL.
- Pop condition: buf_read_o = !buf_empty_i && (state==IDLE || (state==DISP && instr_ready_i && held op is ARITH)). Never asserted in MEMWAIT.
- On a pop, the next state and side effects are decided by the popped class:
  - SETVL:
    - vl <= min(instr_i[19:15], LANES); lane_en_o updates on the same edge.
    - Next state IDLE. Nothing is dispatched.
    - uimm=0 gives vl_o=0 and lane_en_o=0.
  - ARITH or MEM: holding register <= instr_i; next state DISP.
  - ILLEGAL:
    - illegal_o=1 for exactly the following cycle.
    - Next state IDLE. vl is unchanged.
- FSM:
  - IDLE:
    - No valid.
    - Pops whenever the FIFO is non-empty, giving 1 instruction per cycle for back-to-back SETVL/ILLEGAL.
  - DISP:
    - instr_valid_o=1, instr_o=holding register.
    - instr_o and instr_valid_o are held stable until instr_ready_i=1.
    - On handshake with a MEM op -> MEMWAIT; no pop that cycle.
    - On handshake with an ARITH op:
      - If the FIFO is non-empty, pop in the same cycle and apply classification. ARITH followed by ARITH gives 1 dispatch per cycle.
      - Otherwise -> IDLE.
  - MEMWAIT:
    - instr_valid_o=0.
    - On mem_done_i -> IDLE. No pop in the mem_done_i cycle; the first pop is the following cycle.
- mem_done_i is ignored outside MEMWAIT.
- instr_ready_i is ignored while instr_valid_o=0.
- Program order is preserved: a SETVL behind a held instruction is popped only after that instruction's handshake, or after its mem_done_i for MEM. The new vl/lane_en_o are therefore never visible to an earlier instruction.
- No combinational path from instr_i to instr_o or instr_valid_o; both are registered.

Test Plan:
- Reset then idle: FIFO empty, 10 cycles -> buf_read_o=0, instr_valid_o=0, vl_o=4, lane_en_o=4'b1111, busy_o=0.
- ARITH stream: FIFO holds 3 words with opcode 0x57 and funct3=000, instr_ready_i=1 -> pops on consecutive cycles; instr_valid_o high 3 consecutive cycles with the instructions in order; then IDLE.
- Backpressure: one ARITH held in DISP, instr_ready_i=0 for 5 cycles, FIFO non-empty -> instr_o stable, no pop, busy_o=1 until ready.
- MEM serialisation: FIFO holds 0x07 load then ARITH -> load handshake, MEMWAIT; no pop until mem_done_i; ARITH popped the cycle after mem_done_i.
- SETVL: vsetivli with uimm=2 -> vl_o=2, lane_en_o=4'b0011, nothing dispatched. uimm=9 -> vl_o=4. uimm=0 -> lane_en_o=0.
- ILLEGAL and reset: opcode 0x33 popped -> illegal_o single-cycle pulse, no dispatch. Assert rst_i while in DISP -> instr_valid_o=0 immediately, held instruction lost, vl_o=4.

Source files
------------

// File: rtl/vect_instr_fetch.sv
// ---------------------------------------------------------------------------
// vect_instr_fetch
// Vector-side consumer of the scalar-to-vector issue FIFO. Each popped word
// is classified as SETVL, ARITH, MEM or ILLEGAL:
//   SETVL   - executed here (vl / lane enables updated), nothing dispatched
//   ARITH   - held and dispatched over valid/ready; back-to-back capable
//   MEM     - held and dispatched, then fetch stalls until mem_done_i
//   ILLEGAL - dropped, illegal_o pulses for one cycle
//
// Ports:
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   instr_i, buf_empty_i    head of the first-word-fall-through issue FIFO
//   buf_read_o              combinational pop strobe
//   instr_o, instr_valid_o  registered instruction to the execution stage
//   instr_ready_i           execution stage accepts
//   mem_done_i              outstanding vector load/store completed (pulse)
//   vl_o, lane_en_o         current vector length and per-lane enables
//   illegal_o               non-vector instruction dropped (pulse)
//   busy_o                  FSM is not idle
// ---------------------------------------------------------------------------
module vect_instr_fetch #(
  parameter int INSTR_WIDTH = 32,
  parameter int LANES       = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [INSTR_WIDTH-1:0]   instr_i,
  input  logic                     buf_empty_i,
  output logic                     buf_read_o,
  output logic [INSTR_WIDTH-1:0]   instr_o,
  output logic                     instr_valid_o,
  input  logic                     instr_ready_i,
  input  logic                     mem_done_i,
  output logic [$clog2(LANES):0]   vl_o,
  output logic [LANES-1:0]         lane_en_o,
  output logic                     illegal_o,
  output logic                     busy_o
);

  localparam int VLW = $clog2(LANES) + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DISP    = 2'd1;
  localparam logic [1:0] ST_MEMWAIT = 2'd2;

  localparam logic [1:0] CLS_SETVL   = 2'd0;
  localparam logic [1:0] CLS_ARITH   = 2'd1;
  localparam logic [1:0] CLS_MEM     = 2'd2;
  localparam logic [1:0] CLS_ILLEGAL = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [INSTR_WIDTH-1:0] hold_q, hold_d;
  logic                   hold_mem_q, hold_mem_d;
  logic [VLW-1:0]         vl_q, vl_d;
  logic                   illegal_q, illegal_d;

  logic [1:0]             cls;
  logic [6:0]             opcode;
  logic [4:0]             uimm;
  logic [VLW-1:0]         setvl_len;

  assign opcode = instr_i[6:0];
  assign uimm   = instr_i[19:15];

  // NOTE: every combinational output gets a default before any branch, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cls = CLS_ILLEGAL;
    if (opcode == 7'h57) begin
      cls = (instr_i[14:12] == 3'b111 && instr_i[31:30] == 2'b11) ? CLS_SETVL : CLS_ARITH;
    end else if (opcode == 7'h07 || opcode == 7'h27) begin
      cls = CLS_MEM;
    end
  end

  // vl = min(uimm, LANES); the narrowing cast only applies when uimm <= LANES.
  assign setvl_len = (32'(uimm) > LANES) ? VLW'(LANES) : VLW'(uimm);

  // A held MEM op blocks the pop on its handshake cycle so the next word is
  // not consumed until the memory access has completed. Reset suppresses pops.
  assign buf_read_o = !rst_i && !buf_empty_i &&
                      (state_q == ST_IDLE ||
                       (state_q == ST_DISP && instr_ready_i && !hold_mem_q));

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_mem_d = hold_mem_q;
    vl_d       = vl_q;
    illegal_d  = 1'b0;

    case (state_q)
      ST_DISP: begin
        if (instr_ready_i) state_d = hold_mem_q ? ST_MEMWAIT : ST_IDLE;
      end
      ST_MEMWAIT: begin
        if (mem_done_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A pop (from IDLE, or on an ARITH handshake) overrides the above.
    if (buf_read_o) begin
      case (cls)
        CLS_SETVL: begin
          vl_d    = setvl_len;
          state_d = ST_IDLE;
        end
        CLS_ARITH, CLS_MEM: begin
          hold_d     = instr_i;
          hold_mem_d = (cls == CLS_MEM);
          state_d    = ST_DISP;
        end
        default: begin
          illegal_d = 1'b1;
          state_d   = ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      hold_mem_q <= 1'b0;
      vl_q       <= VLW'(LANES);
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_mem_q <= hold_mem_d;
      vl_q       <= vl_d;
      illegal_q  <= illegal_d;
    end
  end

  always_comb begin
    lane_en_o = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_en_o[i] = (i < int'(vl_q));
    end
  end

  assign instr_o       = hold_q;
  assign instr_valid_o = (state_q == ST_DISP);
  assign vl_o          = vl_q;
  assign illegal_o     = illegal_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vect_instr_fetch.sv
// ---------------------------------------------------------------------------
// Bench for vect_instr_fetch. A queue models the issue FIFO; every word
// pushed is classified by a reference model that tracks vl in program order
// and enqueues the expected event (dispatch or illegal drop). A monitor pops
// and compares at every dispatch handshake / illegal pulse, and also watches
// hold-stability under backpressure and memory-op serialisation.
// ---------------------------------------------------------------------------
module tb_vect_instr_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i;
  logic        buf_empty_i;
  logic        buf_read_o;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        mem_done_i;
  logic [2:0]  vl_o;
  logic [3:0]  lane_en_o;
  logic        illegal_o;
  logic        busy_o;

  vect_instr_fetch #(.INSTR_WIDTH(32), .LANES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .buf_empty_i(buf_empty_i),
    .buf_read_o(buf_read_o), .instr_o(instr_o), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .mem_done_i(mem_done_i), .vl_o(vl_o),
    .lane_en_o(lane_en_o), .illegal_o(illegal_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          ill;
    logic [31:0] instr;
    int          vl;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] fifo[$];
  int          m_vl = 4;
  int          errors = 0;
  int          checks = 0;
  bit          rand_mode = 0;
  int          n_left = 0;
  bit          mem_pending = 0;
  int          mem_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_setvl(input logic [4:0] u);
    logic [31:0] w;
    w = 32'hC000_0000;
    w[19:15] = u;
    w[14:12] = 3'b111;
    w[6:0]   = 7'h57;
    return w;
  endfunction

  function automatic logic [31:0] mk_arith(input logic [31:0] r);
    logic [31:0] w;
    w = r;
    w[14:12] = 3'b000;
    w[6:0]   = 7'h57;
    return w;
  endfunction

  // 0 = setvl, 1 = vector op (arith or mem), 2 = illegal
  function automatic int ref_class(input logic [31:0] w);
    if (w[6:0] == 7'h57 && w[14:12] == 3'b111 && w[31:30] == 2'b11) return 0;
    if (w[6:0] == 7'h57 || w[6:0] == 7'h07 || w[6:0] == 7'h27) return 1;
    return 2;
  endfunction

  function automatic bit is_mem_op(input logic [31:0] w);
    return (w[6:0] == 7'h07 || w[6:0] == 7'h27);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 3))
      0: w = mk_setvl(5'($urandom_range(0, 31)));
      1: w[6:0] = 7'h57;
      2: w[6:0] = ($urandom_range(0, 1) != 0) ? 7'h07 : 7'h27;
      default: if (ref_class(w) != 2) w[6:0] = 7'h33;
    endcase
    return w;
  endfunction

  task automatic push(input logic [31:0] w);
    ev_t e;
    fifo.push_back(w);
    case (ref_class(w))
      0: m_vl = (int'(w[19:15]) > 4) ? 4 : int'(w[19:15]);
      1: begin e.ill = 0; e.instr = w; e.vl = m_vl; exp_q.push_back(e); end
      default: begin e.ill = 1; e.instr = w; e.vl = m_vl; exp_q.push_back(e); end
    endcase
  endtask

  task automatic drive_fifo();
    buf_empty_i = (fifo.size() == 0);
    instr_i     = (fifo.size() != 0) ? fifo[0] : 32'h0;
  endtask

  // One clock: sample at the falling edge, update the environment 1 ns after
  // the rising edge.
  task automatic cycle();
    bit pop;
    bit hs_mem;
    @(negedge clk_i);
    pop    = buf_read_o;
    hs_mem = instr_valid_o && instr_ready_i && is_mem_op(instr_o);
    @(posedge clk_i);
    #1;
    if (pop && fifo.size() != 0) void'(fifo.pop_front());
    mem_done_i = 1'b0;
    if (mem_pending) begin
      if (mem_cnt == 0) begin mem_done_i = 1'b1; mem_pending = 0; end
      else mem_cnt--;
    end
    if (hs_mem) begin
      mem_pending = 1;
      mem_cnt     = rand_mode ? int'($urandom_range(0, 5)) : 2;
    end
    if (rand_mode) begin
      instr_ready_i = ($urandom_range(0, 9) < 7);
      if (n_left > 0 && fifo.size() < 6 && $urandom_range(0, 2) != 0) begin
        push(rand_instr());
        n_left--;
      end
    end
    drive_fifo();
  endtask

  // Monitor: scoreboard compare plus protocol watchers.
  initial begin
    bit          prev_stall = 0;
    logic [31:0] prev_instr = '0;
    bit          mem_out = 0;
    bit          just_done = 0;
    ev_t         e;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prev_stall = 0; mem_out = 0; just_done = 0;
        continue;
      end
      if (prev_stall) begin
        check("stall_valid_held", 32'(instr_valid_o), 1);
        check("stall_instr_held", instr_o, prev_instr);
      end
      if (mem_out) begin
        check("memwait_no_pop", 32'(buf_read_o), 0);
        check("memwait_no_valid", 32'(instr_valid_o), 0);
      end
      if (just_done && !buf_empty_i) check("pop_after_mem_done", 32'(buf_read_o), 1);
      just_done = mem_out && mem_done_i;
      if (just_done) mem_out = 0;

      if (instr_valid_o && instr_ready_i) begin
        if (exp_q.size() == 0) check("dispatch_expected", 32'(exp_q.size()), 1);
        else begin
          e = exp_q.pop_front();
          check("dispatch_kind", 32'(e.ill), 0);
          check("dispatch_instr", instr_o, e.instr);
          check("dispatch_vl", 32'(vl_o), 32'(e.vl));
          check("dispatch_lane_en", 32'(lane_en_o), 32'((1 << e.vl) - 1));
        end
        if (is_mem_op(instr_o)) mem_out = 1;
      end
      if (illegal_o) begin
        if (exp_q.size() == 0) check("illegal_expected", 32'(exp_q.size()), 1);
        else begin
          e = exp_q.pop_front();
          check("illegal_kind", 32'(e.ill), 1);
          check("illegal_vl", 32'(vl_o), 32'(e.vl));
        end
      end
      prev_stall = instr_valid_o && !instr_ready_i;
      prev_instr = instr_o;
    end
  end

  initial begin
    logic [31:0] a1;
    int          k;
    rst_i = 1'b1; instr_ready_i = 1'b0; mem_done_i = 1'b0;
    drive_fifo();
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("idle_no_pop", 32'(buf_read_o), 0);
      check("idle_no_valid", 32'(instr_valid_o), 0);
      check("idle_not_busy", 32'(busy_o), 0);
    end
    check("reset_vl", 32'(vl_o), 4);
    check("reset_lane_en", 32'(lane_en_o), 32'hF);
    check("reset_illegal", 32'(illegal_o), 0);

    // ARITH stream: three dispatches on consecutive cycles
    instr_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) push(mk_arith($urandom()));
    drive_fifo();
    repeat (4) cycle();
    check("stream_all_dispatched", 32'(exp_q.size()), 0);
    check("stream_back_idle", 32'(busy_o), 0);

    // Backpressure
    instr_ready_i = 1'b0;
    a1 = mk_arith($urandom());
    push(a1);
    push(mk_arith($urandom()));
    drive_fifo();
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_no_pop", 32'(buf_read_o), 0);
      check("bp_busy", 32'(busy_o), 1);
      check("bp_instr", instr_o, a1);
    end
    instr_ready_i = 1'b1;
    repeat (3) cycle();
    check("bp_drained", 32'(exp_q.size()), 0);

    // MEM serialisation: load then ARITH
    push(32'h0000_2007 | ($urandom() & 32'hFFFF_0F80));
    push(mk_arith($urandom()));
    drive_fifo();
    repeat (5) cycle();
    check("mem_done_cycle_no_pop", 32'(buf_read_o), 0);
    check("mem_done_cycle_busy", 32'(busy_o), 1);
    cycle();
    check("mem_pop_next_cycle", 32'(buf_read_o), 1);
    repeat (3) cycle();
    check("mem_drained", 32'(exp_q.size()), 0);
    check("mem_idle", 32'(busy_o), 0);

    // SETVL
    push(mk_setvl(5'd2)); drive_fifo(); repeat (2) cycle();
    check("setvl2_vl", 32'(vl_o), 2);
    check("setvl2_lane_en", 32'(lane_en_o), 32'h3);
    push(mk_setvl(5'd9)); drive_fifo(); repeat (2) cycle();
    check("setvl9_vl", 32'(vl_o), 4);
    check("setvl9_lane_en", 32'(lane_en_o), 32'hF);
    push(mk_setvl(5'd0)); drive_fifo(); repeat (2) cycle();
    check("setvl0_vl", 32'(vl_o), 0);
    check("setvl0_lane_en", 32'(lane_en_o), 32'h0);
    check("setvl_no_dispatch", 32'(busy_o), 0);

    // ILLEGAL pulse
    push(32'h0020_80B3); drive_fifo();
    cycle();
    check("illegal_pulse", 32'(illegal_o), 1);
    cycle();
    check("illegal_single", 32'(illegal_o), 0);
    check("illegal_vl_kept", 32'(vl_o), 0);

    // Reset while in DISP
    push(mk_setvl(5'd2));
    instr_ready_i = 1'b0;
    push(mk_arith($urandom()));
    push(mk_arith($urandom()));
    drive_fifo();
    repeat (2) cycle();
    check("pre_rst_valid", 32'(instr_valid_o), 1);
    check("pre_rst_vl", 32'(vl_o), 2);
    #2 rst_i = 1'b1;
    #1;
    check("rst_valid_low", 32'(instr_valid_o), 0);
    check("rst_no_pop", 32'(buf_read_o), 0);
    check("rst_vl", 32'(vl_o), 4);
    check("rst_lane_en", 32'(lane_en_o), 32'hF);
    check("rst_not_busy", 32'(busy_o), 0);
    fifo.delete(); exp_q.delete(); m_vl = 4; mem_pending = 0; mem_done_i = 1'b0;
    drive_fifo();
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    repeat (2) cycle();
    check("post_rst_idle", 32'(instr_valid_o), 0);

    // Randomised traffic
    rand_mode = 1;
    n_left    = 400;
    k = 0;
    while ((n_left > 0 || exp_q.size() != 0 || fifo.size() != 0) && k < 8000) begin
      cycle();
      k++;
    end
    check("random_drained", 32'(exp_q.size()), 0);
    rand_mode = 0;
    instr_ready_i = 1'b1;
    repeat (10) cycle();
    check("random_end_idle", 32'(busy_o), 0);
    check("random_end_vl", 32'(vl_o), 32'(m_vl));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
